// File: rtl/lexington_pkg.sv
// Shared types and constants for the Lexington RV32 load/store path.
`default_nettype none
// ============================================================================
// Module   : lexington_pkg
// Purpose  : Memory width encoding, LSU state type and mcause codes
// Revision : 1.0
// ============================================================================
package lexington_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10
   } mem_width_t;

   typedef enum logic [0:0] {
      LSU_IDLE   = 1'b0,
      LSU_ACCESS = 1'b1
   } lsu_state_t;

   localparam logic [3:0] LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] LOAD_FAULT       = 4'd5;
   localparam logic [3:0] STORE_MISALIGNED = 4'd6;
   localparam logic [3:0] STORE_FAULT      = 4'd7;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, strobes, store replication, load extraction.
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Byte-lane formatting between RV32 registers and the DBus
// Revision : 1.0
// ============================================================================
module lsu_align
   import lexington_pkg::*;
(
   input  mem_width_t  chk_width,
   input  logic [1:0]  chk_offset,
   input  mem_width_t  width,
   input  logic [1:0]  offset,
   input  logic        store,
   input  logic        zero_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] rd_data,
   output logic        misaligned,
   output logic [3:0]  strobe,
   output logic [31:0] wr_data,
   output logic [31:0] load_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // The check runs on the incoming request, before it is latched.
   always_comb begin
      misaligned = 1'b0;
      case (chk_width)
         MEM_B:   misaligned = 1'b0;
         MEM_H:   misaligned = chk_offset[0];
         default: misaligned = |chk_offset;
      endcase
   end

   always_comb begin
      strobe  = 4'b0000;
      wr_data = 32'd0;
      if (store) begin
         case (width)
            MEM_B: begin
               strobe  = 4'b0001 << offset;
               wr_data = {4{wdata[7:0]}};
            end
            MEM_H: begin
               strobe  = offset[1] ? 4'b1100 : 4'b0011;
               wr_data = {2{wdata[15:0]}};
            end
            default: begin
               strobe  = 4'b1111;
               wr_data = wdata;
            end
         endcase
      end
   end

   always_comb begin
      lane_b    = rd_data[7:0];
      lane_h    = offset[1] ? rd_data[31:16] : rd_data[15:0];
      load_data = rd_data;
      case (offset)
         2'd0:    lane_b = rd_data[7:0];
         2'd1:    lane_b = rd_data[15:8];
         2'd2:    lane_b = rd_data[23:16];
         default: lane_b = rd_data[31:24];
      endcase
      case (width)
         MEM_B:   load_data = zero_ext ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
         MEM_H:   load_data = zero_ext ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: load_data = rd_data;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
// DBus initiator for loads/stores with precise misalignment and access-fault reporting.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit; word-addressed, byte-strobed DBus master
// Config   : LSU_TIMEOUT_EN adds an ACCESS watchdog of TIMEOUT_CYCLES
// Revision : 1.0
// ============================================================================
module lsu
   import lexington_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  mem_width_t  req_width,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_exc,
   output logic [3:0]  resp_cause,
   output logic        dbus_rd_en,
   output logic        dbus_wr_en,
   output logic [29:0] dbus_addr,
   output logic [31:0] dbus_wr_data,
   output logic [3:0]  dbus_wr_strobe,
   input  logic [31:0] dbus_rd_data,
   input  logic        dbus_ready,
   input  logic        dbus_err
);

   lsu_state_t  state, state_next;
   logic        store_q;
   mem_width_t  width_q;
   logic        unsigned_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic        misaligned;
   logic [3:0]  al_strobe;
   logic [31:0] al_wr_data;
   logic [31:0] al_load_data;
   logic        timeout;
   logic        accept;

   assign accept = (state == LSU_IDLE) && req_valid;

   lsu_align u_align (
      .chk_width  (req_width),
      .chk_offset (req_addr[1:0]),
      .width      (width_q),
      .offset     (addr_q[1:0]),
      .store      (store_q),
      .zero_ext   (unsigned_q),
      .wdata      (wdata_q),
      .rd_data    (dbus_rd_data),
      .misaligned (misaligned),
      .strobe     (al_strobe),
      .wr_data    (al_wr_data),
      .load_data  (al_load_data)
   );

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] tmo_cnt;

   // Held at zero in IDLE so every ACCESS starts counting from 0.
   always_ff @(posedge clk) begin
      if (!rst_n || state == LSU_IDLE) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign timeout = (state == LSU_ACCESS) && (tmo_cnt == TMO_LIMIT);
`else
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= LSU_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         LSU_IDLE:   if (req_valid && !misaligned)  state_next = LSU_ACCESS;
         LSU_ACCESS: if (dbus_ready || timeout)     state_next = LSU_IDLE;
         default:                                   state_next = LSU_IDLE;
      endcase
   end

   always_comb begin
      req_ready      = (state == LSU_IDLE);
      dbus_rd_en     = 1'b0;
      dbus_wr_en     = 1'b0;
      dbus_addr      = 30'd0;
      dbus_wr_data   = 32'd0;
      dbus_wr_strobe = 4'b0000;
      if (state == LSU_ACCESS) begin
         dbus_rd_en     = !store_q;
         dbus_wr_en     = store_q;
         dbus_addr      = addr_q[31:2];
         dbus_wr_data   = al_wr_data;
         dbus_wr_strobe = al_strobe;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         store_q    <= 1'b0;
         width_q    <= MEM_B;
         unsigned_q <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
      end else if (accept) begin
         store_q    <= req_store;
         width_q    <= req_width;
         unsigned_q <= req_unsigned;
         addr_q     <= req_addr;
         wdata_q    <= req_wdata;
      end
   end

   // Response fields are zero except in the single cycle resp_valid is high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_exc   <= 1'b0;
         resp_cause <= 4'd0;
         resp_rdata <= 32'd0;
      end else begin
         resp_valid <= 1'b0;
         resp_exc   <= 1'b0;
         resp_cause <= 4'd0;
         resp_rdata <= 32'd0;
         if (accept && misaligned) begin
            resp_valid <= 1'b1;
            resp_exc   <= 1'b1;
            resp_cause <= req_store ? STORE_MISALIGNED : LOAD_MISALIGNED;
         end else if (state == LSU_ACCESS) begin
            if (dbus_ready) begin
               resp_valid <= 1'b1;
               if (dbus_err) begin
                  resp_exc   <= 1'b1;
                  resp_cause <= store_q ? STORE_FAULT : LOAD_FAULT;
               end else if (!store_q) begin
                  resp_rdata <= al_load_data;
               end
            end else if (timeout) begin
               resp_valid <= 1'b1;
               resp_exc   <= 1'b1;
               resp_cause <= store_q ? STORE_FAULT : LOAD_FAULT;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; timeout checks run when LSU_TIMEOUT_EN is defined.
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Directed vectors with hand-computed expectations
// Revision : 1.0
// ============================================================================
module tb_lsu;
   import lexington_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   mem_width_t  req_width;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_exc;
   logic [3:0]  resp_cause;
   logic        dbus_rd_en;
   logic        dbus_wr_en;
   logic [29:0] dbus_addr;
   logic [31:0] dbus_wr_data;
   logic [3:0]  dbus_wr_strobe;
   logic [31:0] dbus_rd_data;
   logic        dbus_ready;
   logic        dbus_err;

   int n_assert = 0;
   int n_fail   = 0;

   lsu #(.TIMEOUT_CYCLES(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_store      (req_store),
      .req_width      (req_width),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_exc       (resp_exc),
      .resp_cause     (resp_cause),
      .dbus_rd_en     (dbus_rd_en),
      .dbus_wr_en     (dbus_wr_en),
      .dbus_addr      (dbus_addr),
      .dbus_wr_data   (dbus_wr_data),
      .dbus_wr_strobe (dbus_wr_strobe),
      .dbus_rd_data   (dbus_rd_data),
      .dbus_ready     (dbus_ready),
      .dbus_err       (dbus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a request for one edge, then withdraws it.
   task automatic issue(input logic st, input mem_width_t w, input logic uns,
                        input logic [31:0] a, input logic [31:0] d);
      req_valid    = 1'b1;
      req_store    = st;
      req_width    = w;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = d;
      step();
      req_valid    = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_store    = 1'b0;
      req_width    = MEM_W;
      req_unsigned = 1'b0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      dbus_rd_data = 32'd0;
      dbus_ready   = 1'b0;
      dbus_err     = 1'b0;
      step();
      step();
      chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_exc",   {31'd0, resp_exc},   32'd0);
      chk("rst_resp_cause", {28'd0, resp_cause}, 32'd0);
      chk("rst_resp_rdata", resp_rdata,          32'd0);
      chk("rst_enables",    {30'd0, dbus_rd_en, dbus_wr_en}, 32'd0);
      chk("rst_dbus_addr",  {2'd0, dbus_addr},   32'd0);
      chk("rst_strobe",     {28'd0, dbus_wr_strobe}, 32'd0);
      chk("rst_wr_data",    dbus_wr_data,        32'd0);
      rst_n = 1'b1;
      step();

      // SB 0x1003, zero wait states
      issue(1'b1, MEM_B, 1'b0, 32'h0000_1003, 32'h0000_00A5);
      chk("sb_wr_en",   {31'd0, dbus_wr_en}, 32'd1);
      chk("sb_rd_en",   {31'd0, dbus_rd_en}, 32'd0);
      chk("sb_addr",    {2'd0, dbus_addr},   32'h400);
      chk("sb_strobe",  {28'd0, dbus_wr_strobe}, 32'h8);
      chk("sb_wr_data", dbus_wr_data,        32'hA5A5_A5A5);
      chk("sb_ready0",  {31'd0, req_ready},  32'd0);
      chk("sb_no_resp", {31'd0, resp_valid}, 32'd0);
      dbus_ready = 1'b1;
      step();
      dbus_ready = 1'b0;
      chk("sb_resp",    {31'd0, resp_valid}, 32'd1);
      chk("sb_exc",     {31'd0, resp_exc},   32'd0);
      chk("sb_rdata",   resp_rdata,          32'd0);
      chk("sb_idle_en", {30'd0, dbus_rd_en, dbus_wr_en}, 32'd0);
      chk("sb_ready1",  {31'd0, req_ready},  32'd1);

      // LH 0x2002 accepted in the response cycle of the SB
      issue(1'b0, MEM_H, 1'b0, 32'h0000_2002, 32'h0);
      chk("lh_resp_drop", {31'd0, resp_valid}, 32'd0);
      chk("lh_rd_en",   {31'd0, dbus_rd_en}, 32'd1);
      chk("lh_addr",    {2'd0, dbus_addr},   32'h800);
      chk("lh_strobe",  {28'd0, dbus_wr_strobe}, 32'h0);
      chk("lh_wr_data", dbus_wr_data,        32'h0);
      dbus_ready   = 1'b1;
      dbus_rd_data = 32'h8001_7FFF;
      step();
      dbus_ready = 1'b0;
      chk("lh_resp",  {31'd0, resp_valid}, 32'd1);
      chk("lh_rdata", resp_rdata,          32'hFFFF_8001);

      issue(1'b0, MEM_H, 1'b1, 32'h0000_2002, 32'h0);
      dbus_ready = 1'b1;
      step();
      dbus_ready = 1'b0;
      chk("lhu_rdata", resp_rdata, 32'h0000_8001);

      // LB / LBU at byte 1
      issue(1'b0, MEM_B, 1'b0, 32'h0000_2001, 32'h0);
      dbus_ready   = 1'b1;
      dbus_rd_data = 32'h0000_8000;
      step();
      dbus_ready = 1'b0;
      chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
      issue(1'b0, MEM_B, 1'b1, 32'h0000_2001, 32'h0);
      dbus_ready = 1'b1;
      step();
      dbus_ready = 1'b0;
      chk("lbu_rdata", resp_rdata, 32'h0000_0080);

      // Misaligned LW and SH
      issue(1'b0, MEM_W, 1'b0, 32'h0000_3001, 32'h0);
      chk("lw_mis_en",    {30'd0, dbus_rd_en, dbus_wr_en}, 32'd0);
      chk("lw_mis_resp",  {31'd0, resp_valid}, 32'd1);
      chk("lw_mis_exc",   {31'd0, resp_exc},   32'd1);
      chk("lw_mis_cause", {28'd0, resp_cause}, 32'd4);
      chk("lw_mis_ready", {31'd0, req_ready},  32'd1);
      issue(1'b1, MEM_H, 1'b0, 32'h0000_3003, 32'h1234);
      chk("sh_mis_en",    {30'd0, dbus_rd_en, dbus_wr_en}, 32'd0);
      chk("sh_mis_cause", {28'd0, resp_cause}, 32'd6);
      chk("sh_mis_exc",   {31'd0, resp_exc},   32'd1);
      step();
      chk("sh_mis_pulse", {31'd0, resp_valid}, 32'd0);

      // SW with three wait states
      issue(1'b1, MEM_W, 1'b0, 32'h0000_4008, 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) dbus_ready = 1'b1;
         chk("sw_wr_en",  {31'd0, dbus_wr_en}, 32'd1);
         chk("sw_addr",   {2'd0, dbus_addr},   32'h1002);
         chk("sw_data",   dbus_wr_data,        32'hDEAD_BEEF);
         chk("sw_strobe", {28'd0, dbus_wr_strobe}, 32'hF);
         chk("sw_ready0", {31'd0, req_ready},  32'd0);
         chk("sw_noresp", {31'd0, resp_valid}, 32'd0);
         step();
      end
      dbus_ready = 1'b0;
      chk("sw_resp",  {31'd0, resp_valid}, 32'd1);
      chk("sw_exc",   {31'd0, resp_exc},   32'd0);
      step();
      chk("sw_pulse", {31'd0, resp_valid}, 32'd0);

      // SH to upper half
      issue(1'b1, MEM_H, 1'b0, 32'h0000_6002, 32'h1234_BEEF);
      chk("sh_strobe", {28'd0, dbus_wr_strobe}, 32'hC);
      chk("sh_data",   dbus_wr_data,            32'hBEEF_BEEF);
      dbus_ready = 1'b1;
      dbus_err   = 1'b1;
      step();
      dbus_ready = 1'b0;
      dbus_err   = 1'b0;
      chk("sh_err_exc",   {31'd0, resp_exc},   32'd1);
      chk("sh_err_cause", {28'd0, resp_cause}, 32'd7);

      // LB with bus error
      issue(1'b0, MEM_B, 1'b0, 32'h0000_5001, 32'h0);
      dbus_ready   = 1'b1;
      dbus_err     = 1'b1;
      dbus_rd_data = 32'h1234_5678;
      step();
      dbus_ready = 1'b0;
      dbus_err   = 1'b0;
      chk("lb_err_resp",  {31'd0, resp_valid}, 32'd1);
      chk("lb_err_exc",   {31'd0, resp_exc},   32'd1);
      chk("lb_err_cause", {28'd0, resp_cause}, 32'd5);
      chk("lb_err_rdata", resp_rdata,          32'd0);
      step();

`ifdef LSU_TIMEOUT_EN
      // Counter runs 0..4 across five ACCESS cycles, response after the fifth
      begin
         int waited;
         waited = 0;
         issue(1'b0, MEM_W, 1'b0, 32'h0000_7000, 32'h0);
         while (!resp_valid && waited < 20) begin
            step();
            waited++;
         end
         chk("tmo_waited", waited,                   32'd5);
         chk("tmo_resp",   {31'd0, resp_valid},      32'd1);
         chk("tmo_cause",  {28'd0, resp_cause},      32'd5);
         chk("tmo_en",     {30'd0, dbus_rd_en, dbus_wr_en}, 32'd0);
      end
`endif

      // Reset in the middle of an access
      issue(1'b0, MEM_W, 1'b0, 32'h0000_7004, 32'h0);
      chk("rstmid_rd_en", {31'd0, dbus_rd_en}, 32'd1);
      rst_n      = 1'b0;
      dbus_ready = 1'b1;
      step();
      dbus_ready = 1'b0;
      chk("rstmid_en0",   {30'd0, dbus_rd_en, dbus_wr_en}, 32'd0);
      chk("rstmid_resp0", {31'd0, resp_valid}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("rstmid_resp1", {31'd0, resp_valid}, 32'd0);
      chk("rstmid_ready", {31'd0, req_ready},  32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
